// File: rtl/command_frame_parser_if.sv
// -----------------------------------------------------------------------------
// command_frame_parser_if
// Bundles the receiver byte stream that feeds the command frame parser and the
// register-file / ALU request signals the parser produces.
//
// Signals (master = byte source and request consumer, slave = parser):
//   received_data        byte from the synchronized UART receiver path
//   received_data_valid  one-cycle strobe qualifying received_data
//   received_data_error  parity/frame error for the byte, meaningful with valid
//   register_file_*      one-cycle write/read strobes with address and data
//   ALU_enable/function  one-cycle ALU start strobe and its function select
//   command_error        one-cycle pulse on frame abort or unknown command
//   parser_busy          high while a frame is being assembled
//   parser_state         raw FSM state, for debug and assertion binding
//
// Handshake: there is no back-pressure. A byte is transferred in every cycle
// where received_data_valid is high. Every request output is a registered
// single-cycle pulse that appears one cycle after the byte that caused it.
// Address, data and function values hold between pulses.
// -----------------------------------------------------------------------------
interface command_frame_parser_if #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int ALU_FUNCTION_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]         received_data;
  logic                          received_data_valid;
  logic                          received_data_error;
  logic                          register_file_write_enable;
  logic                          register_file_read_enable;
  logic [ADDRESS_WIDTH-1:0]      register_file_address;
  logic [DATA_WIDTH-1:0]         register_file_write_data;
  logic                          ALU_enable;
  logic [ALU_FUNCTION_WIDTH-1:0] ALU_function;
  logic                          command_error;
  logic                          parser_busy;
  logic [2:0]                    parser_state;

  modport master (
    output received_data, received_data_valid, received_data_error,
    input  register_file_write_enable, register_file_read_enable,
           register_file_address, register_file_write_data,
           ALU_enable, ALU_function, command_error, parser_busy, parser_state
  );

  modport slave (
    input  received_data, received_data_valid, received_data_error,
    output register_file_write_enable, register_file_read_enable,
           register_file_address, register_file_write_data,
           ALU_enable, ALU_function, command_error, parser_busy, parser_state
  );
endinterface

// File: rtl/command_frame_parser.sv
// -----------------------------------------------------------------------------
// command_frame_parser
// Decodes command frames arriving as bytes from the receiver path:
//   0xAA addr data    register write
//   0xBB addr         register read
//   0xCC a b func     write operand A to reg 0, operand B to reg 1, start ALU
//   0xDD func         start ALU on current operands
// Malformed bytes, receiver errors and inter-byte gaps longer than the
// timeout abort the frame with a single-cycle command_error pulse.
//
// Ports:
//   reference_clk  sole clock, rising edge
//   reset          asynchronous, active-low
//   bus            command_frame_parser_if.slave (byte input, request outputs)
// -----------------------------------------------------------------------------
module command_frame_parser #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int ALU_FUNCTION_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 4096
) (
  input  logic                    reference_clk,
  input  logic                    reset,
  command_frame_parser_if.slave   bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [DATA_WIDTH-1:0] CMD_WRITE   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_READ    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU     = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ADDR  = 3'd1,
    S_WR_DATA  = 3'd2,
    S_RD_ADDR  = 3'd3,
    S_ALU_A    = 3'd4,
    S_ALU_B    = 3'd5,
    S_ALU_FUNC = 3'd6
  } state_t;

  state_t                        r_state;
  logic [CNT_W-1:0]              r_timeout_count;
  logic [ADDRESS_WIDTH-1:0]      r_wr_addr;
  logic                          r_rf_we;
  logic                          r_rf_re;
  logic [ADDRESS_WIDTH-1:0]      r_rf_addr;
  logic [DATA_WIDTH-1:0]         r_rf_wdata;
  logic                          r_alu_en;
  logic [ALU_FUNCTION_WIDTH-1:0] r_alu_func;
  logic                          r_cmd_err;

  state_t                        w_state_next;
  logic [ADDRESS_WIDTH-1:0]      w_wr_addr_next;
  logic                          w_rf_we_next;
  logic                          w_rf_re_next;
  logic [ADDRESS_WIDTH-1:0]      w_rf_addr_next;
  logic [DATA_WIDTH-1:0]         w_rf_wdata_next;
  logic                          w_alu_en_next;
  logic [ALU_FUNCTION_WIDTH-1:0] w_alu_func_next;
  logic                          w_cmd_err_next;

  logic w_byte_valid;
  logic w_byte_error;
  logic w_addr_in_range;
  logic w_func_in_range;
  logic w_timeout;

  assign w_byte_valid    = bus.received_data_valid;
  assign w_byte_error    = bus.received_data_valid & bus.received_data_error;
  // Any set bit above the field width makes the byte an illegal address/function.
  assign w_addr_in_range = ((bus.received_data >> ADDRESS_WIDTH) == '0);
  assign w_func_in_range = ((bus.received_data >> ALU_FUNCTION_WIDTH) == '0);
  // Expiry only aborts when no byte arrives in the same cycle.
  assign w_timeout       = (r_state != S_IDLE) && (r_timeout_count == TIMEOUT_LAST);

  always_ff @(posedge reference_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wr_addr_next  = r_wr_addr;
    w_rf_we_next    = 1'b0;
    w_rf_re_next    = 1'b0;
    w_alu_en_next   = 1'b0;
    w_cmd_err_next  = 1'b0;
    w_rf_addr_next  = r_rf_addr;
    w_rf_wdata_next = r_rf_wdata;
    w_alu_func_next = r_alu_func;

    if (w_byte_error) begin
      // Errored byte is dropped; in IDLE this is just a pulse, otherwise an abort.
      w_cmd_err_next = 1'b1;
      w_state_next   = S_IDLE;
    end else if (w_byte_valid) begin
      case (r_state)
        S_IDLE: begin
          if (bus.received_data == CMD_WRITE) begin
            w_state_next = S_WR_ADDR;
          end else if (bus.received_data == CMD_READ) begin
            w_state_next = S_RD_ADDR;
          end else if (bus.received_data == CMD_ALU_OPS) begin
            w_state_next = S_ALU_A;
          end else if (bus.received_data == CMD_ALU) begin
            w_state_next = S_ALU_FUNC;
          end else begin
            w_cmd_err_next = 1'b1;
          end
        end
        S_WR_ADDR: begin
          if (w_addr_in_range) begin
            w_wr_addr_next = bus.received_data[ADDRESS_WIDTH-1:0];
            w_state_next   = S_WR_DATA;
          end else begin
            w_cmd_err_next = 1'b1;
            w_state_next   = S_IDLE;
          end
        end
        S_WR_DATA: begin
          w_rf_we_next    = 1'b1;
          w_rf_addr_next  = r_wr_addr;
          w_rf_wdata_next = bus.received_data;
          w_state_next    = S_IDLE;
        end
        S_RD_ADDR: begin
          if (w_addr_in_range) begin
            w_rf_re_next   = 1'b1;
            w_rf_addr_next = bus.received_data[ADDRESS_WIDTH-1:0];
          end else begin
            w_cmd_err_next = 1'b1;
          end
          w_state_next = S_IDLE;
        end
        S_ALU_A: begin
          w_rf_we_next    = 1'b1;
          w_rf_addr_next  = '0;
          w_rf_wdata_next = bus.received_data;
          w_state_next    = S_ALU_B;
        end
        S_ALU_B: begin
          w_rf_we_next    = 1'b1;
          w_rf_addr_next  = ADDRESS_WIDTH'(1);
          w_rf_wdata_next = bus.received_data;
          w_state_next    = S_ALU_FUNC;
        end
        S_ALU_FUNC: begin
          if (w_func_in_range) begin
            w_alu_en_next   = 1'b1;
            w_alu_func_next = bus.received_data[ALU_FUNCTION_WIDTH-1:0];
          end else begin
            w_cmd_err_next = 1'b1;
          end
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end else if (w_timeout) begin
      w_cmd_err_next = 1'b1;
      w_state_next   = S_IDLE;
    end
  end

  // Inter-byte gap counter: restarts on each byte and stays cleared while idle
  // or when the frame is ending this cycle.
  always_ff @(posedge reference_clk or negedge reset) begin
    if (!reset) begin
      r_timeout_count <= '0;
    end else if (w_byte_valid || (r_state == S_IDLE) || (w_state_next == S_IDLE)) begin
      r_timeout_count <= '0;
    end else begin
      r_timeout_count <= r_timeout_count + CNT_W'(1);
    end
  end

  always_ff @(posedge reference_clk or negedge reset) begin
    if (!reset) begin
      r_wr_addr  <= '0;
      r_rf_we    <= 1'b0;
      r_rf_re    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
      r_alu_en   <= 1'b0;
      r_alu_func <= '0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_wr_addr  <= w_wr_addr_next;
      r_rf_we    <= w_rf_we_next;
      r_rf_re    <= w_rf_re_next;
      r_rf_addr  <= w_rf_addr_next;
      r_rf_wdata <= w_rf_wdata_next;
      r_alu_en   <= w_alu_en_next;
      r_alu_func <= w_alu_func_next;
      r_cmd_err  <= w_cmd_err_next;
    end
  end

  assign bus.register_file_write_enable = r_rf_we;
  assign bus.register_file_read_enable  = r_rf_re;
  assign bus.register_file_address      = r_rf_addr;
  assign bus.register_file_write_data   = r_rf_wdata;
  assign bus.ALU_enable                 = r_alu_en;
  assign bus.ALU_function               = r_alu_func;
  assign bus.command_error              = r_cmd_err;
  assign bus.parser_busy                = (r_state != S_IDLE);
  assign bus.parser_state               = r_state;

endmodule

// File: doc/command_frame_parser.md
Name: command_frame_parser

Overview:
- Reference-clock-domain front end of the system controller. Consumes synchronized bytes from the UART receiver path and decodes the four command frames:
  - 0xAA: register write
  - 0xBB: register read
  - 0xCC: ALU with operands
  - 0xDD: ALU without operands
- Drives single-cycle register-file and ALU request strobes.
- Aborts malformed, errored or stalled frames, reporting each abort on a one-cycle error pulse.

Parameters:
- DATA_WIDTH, 8, byte width of received data and of register write data.
- ADDRESS_WIDTH, 4, register file address width (16 entries).
- ALU_FUNCTION_WIDTH, 4, width of the ALU function select.
- TIMEOUT_CYCLES, 4096, maximum reference_clk cycles allowed between consecutive bytes of one frame.

Ports:
- reference_clk, input, 1, sole clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- received_data, input, DATA_WIDTH, synchronized receiver byte.
- received_data_valid, input, 1, one-cycle strobe qualifying received_data.
- received_data_error, input, 1, parity/frame error flag for the byte; sampled only when valid is high.
- register_file_write_enable, output, 1, one-cycle write strobe.
- register_file_read_enable, output, 1, one-cycle read strobe.
- register_file_address, output, ADDRESS_WIDTH, address for the write or read strobe.
- register_file_write_data, output, DATA_WIDTH, data for the write strobe.
- ALU_enable, output, 1, one-cycle ALU start strobe.
- ALU_function, output, ALU_FUNCTION_WIDTH, function select, valid with ALU_enable.
- command_error, output, 1, one-cycle pulse on frame abort or unknown command.
- parser_busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset low, asynchronous): FSM to IDLE, timeout counter cleared. All outputs 0, including address, write data and function.
- Strobes are registered and asserted exactly 1 cycle after the valid cycle of the byte that triggers them. They are never asserted together, except that an operand write and ALU_enable cannot coincide, because each is triggered by a separate byte.
- Address/data/function outputs hold their last value between strobes.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC.
- In IDLE, on a valid byte:
  - 0xAA -> WR_ADDR.
  - 0xBB -> RD_ADDR.
  - 0xCC -> ALU_A.
  - 0xDD -> ALU_FUNC.
  - Any other value -> command_error pulse, stay in IDLE.
- WR_ADDR: latch the low ADDRESS_WIDTH bits -> WR_DATA.
- WR_DATA: write_enable with the latched address and the byte -> IDLE.
- RD_ADDR: read_enable with the address -> IDLE.
- ALU_A: write_enable, address 0, data = byte -> ALU_B.
- ALU_B: write_enable, address 1, data = byte -> ALU_FUNC.
- ALU_FUNC: ALU_enable, ALU_function = low ALU_FUNCTION_WIDTH bits -> IDLE.
- Range checks:
  - An address byte with nonzero bits above ADDRESS_WIDTH -> abort.
  - A function byte with nonzero bits above ALU_FUNCTION_WIDTH -> abort.
  - Data and operand bytes accept the full range.
- Abort: command_error pulse 1 cycle later, FSM to IDLE, no strobe issued for the aborting byte. Strobes already issued earlier in the frame stand (no rollback of an A operand write).
- received_data_error high with valid:
  - The byte is discarded.
  - Outside IDLE: abort.
  - In IDLE: command_error pulse, stay in IDLE.
- Timeout:
  - Counter clears on every valid byte and whenever in IDLE; it increments each cycle outside IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no valid byte: abort.
  - Counter width is clog2(TIMEOUT_CYCLES).
- Valid byte in the same cycle the timeout expires: the byte is processed and the counter clears, with no error.
- No back-pressure: bytes arrive at most once per ~950 cycles. Back-to-back valid cycles must still be handled, one byte per cycle.
- Reset asserted mid-frame: immediate return to IDLE, pending strobes dropped; the next frame parses cleanly.

Test Plan:
- Write: bytes AA, 05, 3C -> write_enable one pulse, address 5, data 0x3C, 1 cycle after the 3C valid. No other strobe, no error.
- Read after write: BB, 05 -> read_enable one pulse, address 5. command_error stays 0; parser_busy falls the same cycle.
- ALU with operands: CC, 12, 34, 01 produces, in order, each as a separate one-cycle pulse:
  - write address 0 data 0x12;
  - write address 1 data 0x34;
  - ALU_enable with function 1.
- ALU without operands, then illegal function: DD, 03 -> ALU_enable with function 3. Then DD, 13 -> command_error pulse, no ALU_enable, parser back in IDLE.
- Error paths:
  - Unknown command 0x7E -> command_error only.
  - AA, 05 then a byte with received_data_error=1 -> abort, no write.
  - AA, then no byte for 4096 cycles -> command_error at the cycle the count reaches 4095.
  - Byte arriving exactly at expiry -> accepted.
- Reset mid-frame: CC, 12, assert reset -> all outputs 0 immediately. After release, AA, 0F, FF -> write address 15 data 0xFF.
